// File: rtl/spike_vote_counter.sv
// spike_vote_counter: per-class spike accumulator with a sequential argmax scan.
// Counts output-neuron spikes per class over a frame, then on frame end walks
// the counters one per cycle to find the winning class, its count and a tie flag.
module spike_vote_counter #(
    parameter int NUM_CLASSES = 18,
    parameter int IDX_W       = 5,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_class,
    input  logic             in_spike,
    input  logic             frame_clear,
    input  logic             frame_end,
    output logic             busy,
    output logic             overrun,
    output logic             result_valid,
    output logic [IDX_W-1:0] result_class,
    output logic [CNT_W-1:0] result_count,
    output logic             result_tie
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_next;
    logic [CNT_W-1:0] count [NUM_CLASSES];

    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] scan_val;
    logic [CNT_W-1:0] best_cnt, best_cnt_next;
    logic [IDX_W-1:0] best_idx, best_idx_next;
    logic             best_tie, best_tie_next;
    logic             accum_hit;
    logic             scan_last;

    // A sample only counts when it carries a spike for an existing class.
    assign accum_hit = in_valid && in_spike && (int'(in_class) < NUM_CLASSES);
    assign scan_last = (scan_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_next   = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                if (frame_end) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // Spike counters: clear, saturating increment, frozen outside ACCUM.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is reset explicitly because a reset must leave
        // every class at zero; it is a register file, not a RAM macro.
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                count[i] <= '0;
            end
        end else if (state == ACCUM) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (frame_clear) begin
                    count[i] <= '0;
                end
                // A spike arriving with a clear becomes the first of the new frame.
                if (accum_hit && (in_class == IDX_W'(i))) begin
                    if (frame_clear) begin
                        count[i] <= CNT_W'(1);
                    end else if (count[i] != CNT_MAX) begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Select the counter addressed by the scan index.
    always_comb begin
        scan_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                scan_val = count[i];
            end
        end
    end

    // Running argmax: strict greater replaces, equal keeps the lower index and flags a tie.
    always_comb begin
        best_cnt_next = best_cnt;
        best_idx_next = best_idx;
        best_tie_next = best_tie;
        if (scan_idx == '0) begin
            best_cnt_next = scan_val;
            best_idx_next = '0;
            best_tie_next = 1'b0;
        end else if (scan_val > best_cnt) begin
            best_cnt_next = scan_val;
            best_idx_next = scan_idx;
            best_tie_next = 1'b0;
        end else if (scan_val == best_cnt) begin
            best_tie_next = 1'b1;
        end
    end

    // Scan datapath, held result registers and the registered overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx     <= '0;
            best_cnt     <= '0;
            best_idx     <= '0;
            best_tie     <= 1'b0;
            result_class <= '0;
            result_count <= '0;
            result_tie   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= (state != ACCUM) && in_valid && in_spike;
            if (state == ACCUM) begin
                scan_idx <= '0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + IDX_W'(1);
                best_cnt <= best_cnt_next;
                best_idx <= best_idx_next;
                best_tie <= best_tie_next;
                // Load the result on the last scan cycle so it is valid in DONE.
                if (scan_last) begin
                    result_class <= best_idx_next;
                    result_count <= best_cnt_next;
                    result_tie   <= best_tie_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_vote_counter.sv
// Directed bench for spike_vote_counter: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_spike_vote_counter;

    localparam int NUM_CLASSES = 18;
    localparam int IDX_W       = 5;
    localparam int CNT_W       = 10;
    localparam int SAT_W       = 4;
    localparam int SCAN_WIN    = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IDX_W-1:0] in_class;
    logic             in_spike;
    logic             frame_clear;
    logic             frame_end;

    logic             busy, overrun, result_valid, result_tie;
    logic [IDX_W-1:0] result_class;
    logic [CNT_W-1:0] result_count;

    logic             s_busy, s_overrun, s_result_valid, s_result_tie;
    logic [IDX_W-1:0] s_result_class;
    logic [SAT_W-1:0] s_result_count;

    int checks = 0;
    int errors = 0;

    spike_vote_counter #(.NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_class(in_class),
        .in_spike(in_spike), .frame_clear(frame_clear), .frame_end(frame_end),
        .busy(busy), .overrun(overrun), .result_valid(result_valid),
        .result_class(result_class), .result_count(result_count), .result_tie(result_tie)
    );

    spike_vote_counter #(.NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_class(in_class),
        .in_spike(in_spike), .frame_clear(frame_clear), .frame_end(frame_end),
        .busy(s_busy), .overrun(s_overrun), .result_valid(s_result_valid),
        .result_class(s_result_class), .result_count(s_result_count), .result_tie(s_result_tie)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spikes(input int cls, input int n, input logic spk);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_spike = spk;
            in_class = IDX_W'(cls);
            tick();
        end
        in_valid = 1'b0;
        in_spike = 1'b0;
    endtask

    task automatic clear_frame();
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
    endtask

    // Issue frame_end (optionally with a spike and/or clear), observe SCAN_WIN
    // cycles, optionally inject a spike plus frame_end at scan cycle inj_at.
    task automatic scan_frame(input string tag, input int pre_cls, input logic with_clear,
                              input int inj_at, input int exp_cls, input int exp_cnt,
                              input logic exp_tie);
        int busy_n, rv_n, rv_at, ov_at;
        logic [IDX_W-1:0] cap_cls;
        logic [CNT_W-1:0] cap_cnt;
        logic             cap_tie;
        busy_n = 0; rv_n = 0; rv_at = -1; ov_at = -1;
        cap_cls = '0; cap_cnt = '0; cap_tie = 1'b0;
        frame_end   = 1'b1;
        frame_clear = with_clear;
        if (pre_cls >= 0) begin
            in_valid = 1'b1; in_spike = 1'b1; in_class = IDX_W'(pre_cls);
        end
        tick();
        frame_end = 1'b0; frame_clear = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
        for (int k = 1; k <= SCAN_WIN; k++) begin
            if (busy) busy_n++;
            if (overrun && ov_at < 0) ov_at = k;
            if (result_valid) begin
                rv_n++;
                rv_at   = k;
                cap_cls = result_class;
                cap_cnt = result_count;
                cap_tie = result_tie;
            end
            if (k == inj_at) begin
                in_valid = 1'b1; in_spike = 1'b1; in_class = IDX_W'(exp_cls); frame_end = 1'b1;
            end
            tick();
            in_valid = 1'b0; in_spike = 1'b0; frame_end = 1'b0;
        end
        check({tag, "_busy_cycles"}, busy_n, NUM_CLASSES);
        check({tag, "_valid_pulses"}, rv_n, 1);
        check({tag, "_valid_at"}, rv_at, NUM_CLASSES + 1);
        check({tag, "_overrun_at"}, ov_at, (inj_at > 0) ? inj_at + 1 : -1);
        check({tag, "_class"}, cap_cls, exp_cls);
        check({tag, "_count"}, cap_cnt, exp_cnt);
        check({tag, "_tie"}, cap_tie, exp_tie);
        check({tag, "_class_held"}, result_class, exp_cls);
    endtask

    initial begin
        int rv_seen;
        rst = 1'b1; in_valid = 1'b0; in_class = '0; in_spike = 1'b0;
        frame_clear = 1'b0; frame_end = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_valid", result_valid, 0);
        check("rst_class", result_class, 0);
        check("rst_count", result_count, 0);
        check("rst_tie", result_tie, 0);

        // Basic frame: class 3 wins with 5.
        clear_frame();
        spikes(3, 5, 1'b1);
        spikes(7, 2, 1'b1);
        spikes(0, 1, 1'b1);
        scan_frame("basic", -1, 1'b0, 0, 3, 5, 1'b0);

        // Tie between 4 and 11: lower index wins.
        clear_frame();
        spikes(11, 6, 1'b1);
        spikes(4, 6, 1'b1);
        scan_frame("tie", -1, 1'b0, 0, 4, 6, 1'b1);

        // Saturation: 20 spikes, the 4-bit instance stops at 15.
        clear_frame();
        spikes(2, 20, 1'b1);
        scan_frame("sat_wide", -1, 1'b0, 0, 2, 20, 1'b0);
        check("sat_class", s_result_class, 2);
        check("sat_count", s_result_count, 15);

        // Spike on the same cycle as frame_end is counted.
        clear_frame();
        scan_frame("end_spike", 5, 1'b0, 0, 5, 1, 1'b0);

        // frame_clear with a spike: that spike starts the new frame.
        clear_frame();
        spikes(1, 3, 1'b1);
        in_valid = 1'b1; in_spike = 1'b1; in_class = IDX_W'(9); frame_clear = 1'b1;
        tick();
        in_valid = 1'b0; in_spike = 1'b0; frame_clear = 1'b0;
        scan_frame("clr_spike", -1, 1'b0, 0, 9, 1, 1'b0);

        // Filtering: non-spikes and out-of-range class change nothing; rescan
        // without clear returns the retained counts.
        spikes(2, 3, 1'b0);
        check("filt_nospike_ovr", overrun, 0);
        spikes(20, 2, 1'b1);
        check("filt_range_ovr", overrun, 0);
        scan_frame("filt", -1, 1'b0, 0, 9, 1, 1'b0);

        // Overrun: spike plus frame_end mid-scan is dropped and reported.
        clear_frame();
        spikes(6, 4, 1'b1);
        scan_frame("ovr", -1, 1'b0, 3, 6, 4, 1'b0);

        // Clear and end together: scan of an empty frame.
        spikes(1, 2, 1'b1);
        scan_frame("clr_end", -1, 1'b1, 0, 0, 0, 1'b1);

        // Reset mid-scan aborts with no result.
        clear_frame();
        spikes(8, 3, 1'b1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tie", result_tie, 0);
        check("mid_rst_class", result_class, 0);
        check("mid_rst_count", result_count, 0);
        rv_seen = 0;
        for (int k = 0; k < SCAN_WIN; k++) begin
            if (result_valid || busy) rv_seen++;
            tick();
        end
        check("mid_rst_no_result", rv_seen, 0);
        scan_frame("post_rst_zero", -1, 1'b0, 0, 0, 0, 1'b1);

        // Clean frame after the aborted one.
        clear_frame();
        spikes(12, 2, 1'b1);
        spikes(13, 1, 1'b1);
        scan_frame("post_rst", -1, 1'b0, 0, 12, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_vote_counter.md
# spike_vote_counter

Downstream stage of the integrate-and-fire output neurons in the bin-ratio ensemble SNN. It counts output spikes per class over an inference frame (all timesteps of all ensemble members) and, on frame end, scans the counters to produce the winning class (argmax), its vote count and a tie flag. It turns the per-neuron `spike_out` stream into a single classification result per frame.

## Interface
Parameters:
- `NUM_CLASSES`, 18: number of output classes (counters).
- `IDX_W`, 5: width of the class index; must satisfy 2^IDX_W >= NUM_CLASSES.
- `CNT_W`, 10: width of each spike counter.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  spike sample present this cycle.
- `in_class`  in  IDX_W  output-neuron class index of the sample.
- `in_spike`  in  1  the neuron's `spike_out` value; only 1 increments a counter.
- `frame_clear`  in  1  zero all counters (start of frame).
- `frame_end`  in  1  frame complete; start argmax scan.
- `busy`  out  1  high while scanning.
- `overrun`  out  1  one-cycle pulse when an input is dropped because the block is busy.
- `result_valid`  out  1  one-cycle pulse carrying the result.
- `result_class`  out  IDX_W  winning class index; held until the next result.
- `result_count`  out  CNT_W  winner's spike count; held.
- `result_tie`  out  1  another class had an equal count; held.

## Operation
- States: ACCUM, SCAN, DONE. Reset enters ACCUM.
- Reset: all counters 0, state ACCUM, all outputs 0.
- ACCUM:
  - A sample with `in_valid`=1, `in_spike`=1 and `in_class` < NUM_CLASSES increments `count[in_class]`.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - `in_class` >= NUM_CLASSES is ignored, with no overrun pulse.
  - `in_spike`=0 has no effect.
- `frame_clear` in ACCUM zeros all counters next cycle.
  - With a simultaneous valid spike, that sample becomes the first of the new frame (its counter = 1, all others 0).
- `frame_end` in ACCUM moves the block to SCAN.
  - A simultaneous valid spike is counted before the scan.
  - If `frame_clear` and `frame_end` are both high, clear takes effect and the scan runs on the cleared counters. The result is class 0, count 0, and tie=1 when NUM_CLASSES>1.
- SCAN:
  - Index i runs 0..NUM_CLASSES-1, one counter per cycle.
  - Running best is initialised from index 0.
  - `count[i]` > best replaces the best and clears the tie flag.
  - `count[i]` == best (i>0) sets the tie flag and keeps the lower index.
- DONE (one cycle): register the result, pulse `result_valid`, return to ACCUM.
- Counters are retained after the scan until `frame_clear`, so a second `frame_end` without a clear rescans the same data.
- Overrun: `in_valid`&`in_spike` asserted during SCAN or DONE is dropped and `overrun` pulses the next cycle.
- `frame_clear` or `frame_end` during SCAN or DONE is ignored, with no pulse.
- Reset asserted mid-scan aborts the scan: no `result_valid` is produced, counters and outputs return to 0, state is ACCUM.

## Timing
- Increment latency: a sample at cycle t is visible in the counter at t+1.
- Back-to-back samples to the same class every cycle are fully counted; no throughput loss in ACCUM.
- With `frame_end` at cycle t:
  - `busy`=1 from t+1 through t+NUM_CLASSES (SCAN covers cycles t+1..t+NUM_CLASSES).
  - DONE at t+NUM_CLASSES+1, with `result_valid`=1 for exactly that cycle and result outputs updated the same cycle.
  - Inputs are accepted again from t+NUM_CLASSES+2.
- Total latency is NUM_CLASSES+1 cycles: 19 cycles for the default.
- `overrun` is a registered pulse, high in the cycle after the dropped sample.
- `result_class`, `result_count` and `result_tie` change only in DONE or on reset.

## Test plan
- Reset then frame (defaults): clear; spikes class 3 ×5, class 7 ×2, class 0 ×1; `frame_end` at t.
  - Required: `result_valid` at t+19 only, class 3, count 5, tie 0, `busy` high t+1..t+18.
- Tie: class 4 ×6 and class 11 ×6, all others 0.
  - Required: class 4, count 6, tie 1.
- Saturation (CNT_W=4): 20 spikes to class 2.
  - Required: count 15, class 2.
- Simultaneous events and filtering:
  - Valid spike class 5 on the same cycle as `frame_end` → counted (count 1 if otherwise empty).
  - `frame_clear` + spike class 9 → counter 9 = 1, all others 0.
  - `in_spike`=0 or `in_class`=20 → no change, no overrun.
- Overrun: spike during SCAN.
  - Required: `overrun` pulse the next cycle; that spike is absent from counts; result unchanged.
  - `frame_end` issued mid-scan → no second result.
- Reset mid-scan: `rst` asserted at t+5 after `frame_end`.
  - Required: no `result_valid`; all outputs and counters 0; a subsequent clean frame produces a correct result.
